stage_sequencer: RTL and testbench

Parametrised N-stage launch-vehicle staging controller. It walks the vehicle through ignition, burn, detach and coast for each stage. For each stage it presents specific impulse, initial mass, propellant mass and burn time to the velocity calculator, and drives that calculator's active-low reset. It tracks the remaining vehicle mass, with a per-stage flag that selects whether the stage's dry mass is jettisoned after its burn. The block replaces hard-wired four-stage selection logic, adds a per-stage burn watchdog and abort, and sits between mission control stimulus and the velocity/integration chain.

---
 rtl/stage_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_stage_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer.sv
// N-stage launch-vehicle staging controller: sequences ignition, burn, detach and coast
// per stage, feeds stage parameters to the velocity calculator and tracks vehicle mass.
module stage_sequencer #(
    parameter int                      N_STAGES     = 4,
    parameter int                      W            = 64,
    parameter logic [N_STAGES*W-1:0]   ISP_TABLE    = {W'(421), W'(421), W'(421), W'(263)},
    parameter logic [N_STAGES*W-1:0]   PROP_TABLE   = {W'(83864), W'(39136), W'(456100), W'(2077000)},
    parameter logic [N_STAGES*W-1:0]   BURN_TABLE   = {W'(335), W'(165), W'(360), W'(168)},
    parameter logic [N_STAGES*W-1:0]   DRY_TABLE    = {W'(0), W'(15200), W'(40100), W'(137000)},
    parameter logic [N_STAGES-1:0]     DETACH_MASK  = 4'b0011,
    parameter logic [W-1:0]            PAYLOAD      = W'(27003),
    parameter int                      ARM_CYCLES   = 1,
    parameter int                      COAST_CYCLES = 0,
    parameter int                      TIMEOUT_CYC  = 0,
    localparam int                     SW           = $clog2(N_STAGES + 1)
) (
    input  logic          CLK,
    input  logic          RESETB,
    input  logic          start,
    input  logic          abort,
    input  logic          ignition_end,
    output logic [SW-1:0] stage_idx,
    output logic [W-1:0]  specific_impulse,
    output logic [W-1:0]  initial_weight,
    output logic [W-1:0]  propellant_weight,
    output logic [W-1:0]  burntime,
    output logic          calc_resetb,
    output logic          stage_active,
    output logic          detach_pulse,
    output logic          mission_done,
    output logic          fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ARM,
        S_BURN,
        S_DETACH,
        S_DONE
    } state_t;

    function automatic logic [W-1:0] pick(input logic [N_STAGES*W-1:0] tbl, input int s);
        return W'(tbl >> (s * W));
    endfunction

    function automatic logic [W-1:0] sat_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

    function automatic logic [W-1:0] preload();
        logic [W-1:0] acc;
        acc = PAYLOAD;
        for (int s = 0; s < N_STAGES; s++) begin
            acc = acc + pick(PROP_TABLE, s) + pick(DRY_TABLE, s);
        end
        return acc;
    endfunction

    localparam logic [W-1:0] MASS_INIT = preload();

    state_t        state_q, state_d;
    logic [SW-1:0] stage_q, stage_d;
    logic [W-1:0]  mass_q, mass_d;
    logic [W-1:0]  isp_q, isp_d;
    logic [W-1:0]  iw_q, iw_d;
    logic [W-1:0]  pw_q, pw_d;
    logic [W-1:0]  bt_q, bt_d;
    logic [31:0]   arm_q, arm_d;
    logic [31:0]   wd_q, wd_d;
    logic [31:0]   coast_q, coast_d;
    logic          det_q, det_d;
    logic          done_q, done_d;
    logic          fault_q, fault_d;

    logic          last_stage;
    logic          wd_expired;
    logic          fail;
    logic          drop_dry;

    assign last_stage = (stage_q == SW'(N_STAGES - 1));
    assign wd_expired = (TIMEOUT_CYC != 0) && (wd_q == 32'(TIMEOUT_CYC - 1));
    assign drop_dry   = 1'(DETACH_MASK >> stage_q);

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            state_q <= S_IDLE;
            stage_q <= '0;
            mass_q  <= MASS_INIT;
            isp_q   <= '0;
            iw_q    <= '0;
            pw_q    <= '0;
            bt_q    <= W'(1);
            arm_q   <= '0;
            wd_q    <= '0;
            coast_q <= '0;
            det_q   <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            mass_q  <= mass_d;
            isp_q   <= isp_d;
            iw_q    <= iw_d;
            pw_q    <= pw_d;
            bt_q    <= bt_d;
            arm_q   <= arm_d;
            wd_q    <= wd_d;
            coast_q <= coast_d;
            det_q   <= det_d;
            done_q  <= done_d;
            fault_q <= fault_d;
        end
    end

    // abort outranks ignition_end and the watchdog in every active state
    always_comb begin
        state_d = state_q;
        fail    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (abort) begin
                    state_d = S_DONE;
                    fail    = 1'b1;
                end else begin
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                if (abort) begin
                    state_d = S_DONE;
                    fail    = 1'b1;
                end else if (arm_q == '0) begin
                    state_d = S_BURN;
                end
            end
            S_BURN: begin
                if (abort) begin
                    state_d = S_DONE;
                    fail    = 1'b1;
                end else if (ignition_end) begin
                    state_d = S_DETACH;
                end else if (wd_expired) begin
                    state_d = S_DONE;
                    fail    = 1'b1;
                end
            end
            S_DETACH: begin
                if (abort) begin
                    state_d = S_DONE;
                    fail    = 1'b1;
                end else if (coast_q == '0) begin
                    state_d = last_stage ? S_DONE : S_LOAD;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        stage_d = stage_q;
        mass_d  = mass_q;
        isp_d   = isp_q;
        iw_d    = iw_q;
        pw_d    = pw_q;
        bt_d    = bt_q;
        arm_d   = arm_q;
        coast_d = coast_q;
        det_d   = 1'b0;
        wd_d    = (state_q == S_BURN) ? (wd_q + 32'd1) : '0;
        done_d  = done_q | (state_d == S_DONE);
        fault_d = fault_q | fail;

        if (state_q == S_LOAD && state_d == S_ARM) begin
            isp_d = pick(ISP_TABLE, int'(stage_q));
            iw_d  = mass_q;
            pw_d  = pick(PROP_TABLE, int'(stage_q));
            bt_d  = pick(BURN_TABLE, int'(stage_q));
            arm_d = 32'(ARM_CYCLES - 1);
        end else if (state_q == S_ARM && arm_q != '0) begin
            arm_d = arm_q - 32'd1;
        end

        // mass update and coast preload happen as DETACH is entered
        if (state_q == S_BURN && state_d == S_DETACH) begin
            mass_d  = sat_sub(mass_q, pick(PROP_TABLE, int'(stage_q)));
            if (drop_dry) begin
                mass_d = sat_sub(mass_d, pick(DRY_TABLE, int'(stage_q)));
                det_d  = 1'b1;
            end
            coast_d = 32'(COAST_CYCLES);
        end else if (state_q == S_DETACH && coast_q != '0) begin
            coast_d = coast_q - 32'd1;
        end

        if (state_q == S_DETACH && state_d == S_LOAD) begin
            stage_d = stage_q + SW'(1);
        end
    end

    always_comb begin
        stage_active = (state_q == S_BURN);
        case (state_q)
            S_LOAD, S_BURN, S_DETACH: calc_resetb = 1'b1;
            S_DONE:                   calc_resetb = ~fault_q;
            default:                  calc_resetb = 1'b0;
        endcase
    end

    assign stage_idx         = stage_q;
    assign specific_impulse  = isp_q;
    assign initial_weight    = iw_q;
    assign propellant_weight = pw_q;
    assign burntime          = bt_q;
    assign detach_pulse      = det_q;
    assign mission_done      = done_q;
    assign fault             = fault_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: default mission, abort, reset, coast timing and watchdog.
module tb_stage_sequencer;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic        rstn0, start0, abort0, ie0;
    logic [2:0]  idx0;
    logic [63:0] isp0, iw0, pw0, bt0;
    logic        crb0, act0, det0, done0, flt0;

    logic        rstn1, start1, abort1, ie1;
    logic [2:0]  idx1;
    logic [63:0] isp1, iw1, pw1, bt1;
    logic        crb1, act1, det1, done1, flt1;

    logic        rstn2, start2, abort2, ie2;
    logic [2:0]  idx2;
    logic [63:0] isp2, iw2, pw2, bt2;
    logic        crb2, act2, det2, done2, flt2;

    stage_sequencer u0 (
        .CLK(CLK), .RESETB(rstn0), .start(start0), .abort(abort0), .ignition_end(ie0),
        .stage_idx(idx0), .specific_impulse(isp0), .initial_weight(iw0),
        .propellant_weight(pw0), .burntime(bt0), .calc_resetb(crb0),
        .stage_active(act0), .detach_pulse(det0), .mission_done(done0), .fault(flt0)
    );

    stage_sequencer #(.COAST_CYCLES(4)) u1 (
        .CLK(CLK), .RESETB(rstn1), .start(start1), .abort(abort1), .ignition_end(ie1),
        .stage_idx(idx1), .specific_impulse(isp1), .initial_weight(iw1),
        .propellant_weight(pw1), .burntime(bt1), .calc_resetb(crb1),
        .stage_active(act1), .detach_pulse(det1), .mission_done(done1), .fault(flt1)
    );

    stage_sequencer #(.TIMEOUT_CYC(10)) u2 (
        .CLK(CLK), .RESETB(rstn2), .start(start2), .abort(abort2), .ignition_end(ie2),
        .stage_idx(idx2), .specific_impulse(isp2), .initial_weight(iw2),
        .propellant_weight(pw2), .burntime(bt2), .calc_resetb(crb2),
        .stage_active(act2), .detach_pulse(det2), .mission_done(done2), .fault(flt2)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Entered just after the edge into ARM of stage s; leaves just after the edge into
    // ARM of stage s+1, or into DONE for the last stage.
    task automatic stage_cycle(input int s, input logic [63:0] exp_iw, input logic exp_det,
                               input logic last);
        chk64("arm_idx", 64'(idx0), 64'(s));
        chk64("arm_iw", iw0, exp_iw);
        chk1("arm_crb", crb0, 1'b0);
        tick();
        chk1("burn_act", act0, 1'b1);
        chk1("burn_crb", crb0, 1'b1);
        repeat (4) tick();
        ie0 = 1'b1;
        tick();
        ie0 = 1'b0;
        chk1("det_act", act0, 1'b0);
        chk1("det_pulse", det0, exp_det);
        tick();
        if (last) begin
            chk1("done", done0, 1'b1);
            chk1("done_fault", flt0, 1'b0);
        end else begin
            chk1("load_pulse_clr", det0, 1'b0);
            tick();
        end
    endtask

    task automatic reset0();
        rstn0 = 1'b0;
        tick();
        rstn0 = 1'b1;
        tick();
    endtask

    initial begin
        rstn0 = 1'b1; start0 = 1'b0; abort0 = 1'b0; ie0 = 1'b0;
        rstn1 = 1'b1; start1 = 1'b0; abort1 = 1'b0; ie1 = 1'b0;
        rstn2 = 1'b1; start2 = 1'b0; abort2 = 1'b0; ie2 = 1'b0;
        #1;
        rstn0 = 1'b0; rstn1 = 1'b0; rstn2 = 1'b0;
        #1;
        chk64("rst_idx", 64'(idx0), 64'd0);
        chk64("rst_isp", isp0, 64'd0);
        chk64("rst_iw", iw0, 64'd0);
        chk64("rst_pw", pw0, 64'd0);
        chk64("rst_bt", bt0, 64'd1);
        chk1("rst_crb", crb0, 1'b0);
        chk1("rst_act", act0, 1'b0);
        chk1("rst_det", det0, 1'b0);
        chk1("rst_done", done0, 1'b0);
        chk1("rst_fault", flt0, 1'b0);
        tick();
        tick();
        rstn0 = 1'b1; rstn1 = 1'b1; rstn2 = 1'b1;
        tick();
        chk1("idle_act", act0, 1'b0);
        chk1("idle_crb", crb0, 1'b0);

        // full default mission
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk1("load_act", act0, 1'b0);
        chk1("load_crb", crb0, 1'b1);
        chk64("load_iw_hold", iw0, 64'd0);
        tick();
        chk64("s0_isp", isp0, 64'd263);
        chk64("s0_pw", pw0, 64'd2077000);
        chk64("s0_bt", bt0, 64'd168);
        chk1("arm_act", act0, 1'b0);
        stage_cycle(0, 64'd2875403, 1'b1, 1'b0);
        chk64("s1_isp", isp0, 64'd421);
        chk64("s1_pw", pw0, 64'd456100);
        chk64("s1_bt", bt0, 64'd360);
        stage_cycle(1, 64'd661403, 1'b1, 1'b0);
        stage_cycle(2, 64'd165203, 1'b0, 1'b0);
        chk64("s3_pw", pw0, 64'd83864);
        chk64("s3_bt", bt0, 64'd335);
        stage_cycle(3, 64'd126067, 1'b0, 1'b1);
        chk64("done_idx", 64'(idx0), 64'd3);
        chk1("done_crb", crb0, 1'b1);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick();
        chk1("done_start_ign", done0, 1'b1);
        chk1("done_start_act", act0, 1'b0);
        chk1("done_start_crb", crb0, 1'b1);

        // abort coinciding with ignition_end in stage 1
        reset0();
        chk1("rst2_done", done0, 1'b0);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick();
        stage_cycle(0, 64'd2875403, 1'b1, 1'b0);
        tick();
        chk1("ab_burn", act0, 1'b1);
        ie0 = 1'b1;
        abort0 = 1'b1;
        tick();
        ie0 = 1'b0;
        abort0 = 1'b0;
        chk1("ab_done", done0, 1'b1);
        chk1("ab_fault", flt0, 1'b1);
        chk1("ab_det", det0, 1'b0);
        chk1("ab_crb", crb0, 1'b0);
        chk1("ab_act", act0, 1'b0);
        chk64("ab_idx", 64'(idx0), 64'd1);
        tick();
        chk1("ab_fault_sticky", flt0, 1'b1);
        chk1("ab_det_later", det0, 1'b0);

        // asynchronous reset in the middle of stage 2 burn
        reset0();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick();
        stage_cycle(0, 64'd2875403, 1'b1, 1'b0);
        stage_cycle(1, 64'd661403, 1'b1, 1'b0);
        tick();
        tick();
        chk1("mid_burn", act0, 1'b1);
        #2;
        rstn0 = 1'b0;
        #1;
        chk1("mid_rst_act", act0, 1'b0);
        chk64("mid_rst_iw", iw0, 64'd0);
        chk64("mid_rst_bt", bt0, 64'd1);
        chk64("mid_rst_idx", 64'(idx0), 64'd0);
        chk1("mid_rst_crb", crb0, 1'b0);
        tick();
        rstn0 = 1'b1;
        tick();
        chk1("post_rst_act", act0, 1'b0);
        chk1("post_rst_crb", crb0, 1'b0);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick();
        chk64("restart_iw", iw0, 64'd2875403);
        chk64("restart_idx", 64'(idx0), 64'd0);

        // coast timing with COAST_CYCLES=4
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        tick();
        chk1("c_burn", act1, 1'b1);
        ie1 = 1'b1;
        tick();
        ie1 = 1'b0;
        chk1("c_det_pulse", det1, 1'b1);
        chk1("c_det_crb", crb1, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk1("c_coast_crb", crb1, 1'b1);
        end
        chk1("c_coast_act", act1, 1'b0);
        tick();
        chk1("c_arm_crb", crb1, 1'b0);
        chk64("c_arm_idx", 64'(idx1), 64'd1);
        chk64("c_arm_iw", iw1, 64'd661403);
        tick();
        chk1("c_burn2", act1, 1'b1);

        // watchdog with TIMEOUT_CYC=10
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        tick();
        tick();
        chk1("w_burn", act2, 1'b1);
        repeat (9) tick();
        chk1("w_nine_fault", flt2, 1'b0);
        chk1("w_nine_act", act2, 1'b1);
        tick();
        chk1("w_fault", flt2, 1'b1);
        chk1("w_done", done2, 1'b1);
        chk1("w_crb", crb2, 1'b0);
        chk1("w_act", act2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
